// File: rtl/sum3_stream_accumulator.sv
// sum3_stream_accumulator
//   Two-stage valid/ready stream wrapper around a three-operand 8-bit
//   carry-lookahead adder. Each accepted beat yields the exact 10-bit sum
//   a+b+c+cin and a running per-frame total (modulo 2^ACC_W) with a sticky
//   wrap flag. The frame total restarts after a beat flagged with in_last.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : input handshake
//   in_a, in_b, in_c    : 8-bit operands
//   in_cin              : carry-in (weight 1)
//   in_last             : final beat of the current frame
//   out_valid/out_ready : output handshake
//   out_sum             : 10-bit exact sum of this beat
//   out_acc             : frame total including this beat, modulo 2^ACC_W
//   out_ovf             : frame total has wrapped at least once so far
//   out_last            : in_last of this beat

// carry_lookahead_adder_3_8bits
//   a + b + c + cin = {cout_2, cout_1, sum}, range 0..766.
//   A carry-save layer reduces the three operands to two; the carry vector's
//   top bit (weight 256) is merged with the final carry out of the 8-bit
//   lookahead adder to form cout_1/cout_2.
module carry_lookahead_adder_3_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout_1,
  output logic       cout_2
);

  logic [7:0] csa_s;
  logic [7:0] csa_k;
  logic [7:0] op_y;
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] cy;

  // Carries c[i+1] for a 4-bit group from bitwise generate/propagate.
  function automatic logic [3:0] cla4(input logic [3:0] gi, input logic [3:0] pi,
                                      input logic ci);
    logic [3:0] co;
    co[0] = gi[0] | (pi[0] & ci);
    co[1] = gi[1] | (pi[1] & gi[0]) | (&pi[1:0] & ci);
    co[2] = gi[2] | (pi[2] & gi[1]) | (&pi[2:1] & gi[0]) | (&pi[2:0] & ci);
    co[3] = gi[3] | (pi[3] & gi[2]) | (&pi[3:2] & gi[1]) | (&pi[3:1] & gi[0])
          | (&pi[3:0] & ci);
    return co;
  endfunction

  always_comb begin
    csa_s = a ^ b ^ c;
    csa_k = (a & b) | (a & c) | (b & c);
    // cin occupies the free LSB slot of the left-shifted carry vector
    op_y  = {csa_k[6:0], cin};
    g     = csa_s & op_y;
    p     = csa_s ^ op_y;
    cy[0] = 1'b0;
    cy[4:1] = cla4(g[3:0], p[3:0], 1'b0);
    cy[8:5] = cla4(g[7:4], p[7:4], cy[4]);
    sum    = p ^ cy[7:0];
    cout_1 = csa_k[7] ^ cy[8];
    cout_2 = csa_k[7] & cy[8];
  end

endmodule

module sum3_stream_accumulator #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [7:0]       in_c,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_sum,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             out_last
);

  if (ACC_W < 10) begin : g_bad_acc_w
    $error("sum3_stream_accumulator: ACC_W must be at least 10");
  end

  logic             s1_valid;
  logic [7:0]       s1_a;
  logic [7:0]       s1_b;
  logic [7:0]       s1_c;
  logic             s1_cin;
  logic             s1_last;
  logic             s2_ready;
  logic             take_in;
  logic             load;
  logic [7:0]       add_sum;
  logic             add_cout_1;
  logic             add_cout_2;
  logic [9:0]       sum10;
  logic [ACC_W-1:0] acc_run;
  logic             ovf_run;
  logic [ACC_W:0]   acc_ext;

  always_comb begin
    s2_ready = !out_valid || out_ready;
    in_ready = !s1_valid || s2_ready;
    take_in  = in_valid && in_ready;
    load     = s1_valid && s2_ready;
    sum10    = {add_cout_2, add_cout_1, add_sum};
    // extra MSB captures the wrap out of bit ACC_W-1
    acc_ext  = {1'b0, acc_run} + {{(ACC_W-9){1'b0}}, sum10};
  end

  carry_lookahead_adder_3_8bits u_add (
    .a      (s1_a),
    .b      (s1_b),
    .c      (s1_c),
    .cin    (s1_cin),
    .sum    (add_sum),
    .cout_1 (add_cout_1),
    .cout_2 (add_cout_2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_cin   <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      if (take_in) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_c     <= in_c;
        s1_cin   <= in_cin;
        s1_last  <= in_last;
      end else if (load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_last  <= 1'b0;
      acc_run   <= '0;
      ovf_run   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_sum   <= sum10;
        out_acc   <= acc_ext[ACC_W-1:0];
        out_ovf   <= ovf_run | acc_ext[ACC_W];
        out_last  <= s1_last;
        if (s1_last) begin
          acc_run <= '0;
          ovf_run <= 1'b0;
        end else begin
          acc_run <= acc_ext[ACC_W-1:0];
          ovf_run <= ovf_run | acc_ext[ACC_W];
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sum3_stream_accumulator.sv
// Directed and randomized checks of sum3_stream_accumulator. Two instances
// share all inputs: the default ACC_W=16 and an ACC_W=10 copy used to
// exercise frame-total wrap. Inputs change at the falling edge, outputs are
// sampled 1 ns later.
module tb_sum3_stream_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  in_c;
  logic        in_cin;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_sum;
  logic [15:0] out_acc;
  logic        out_ovf;
  logic        out_last;

  logic        in_ready10;
  logic        out_valid10;
  logic [9:0]  out_sum10;
  logic [9:0]  out_acc10;
  logic        out_ovf10;
  logic        out_last10;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct packed {
    logic [9:0]  sum;
    logic [15:0] acc;
    logic        ovf;
    logic        last;
  } beat_t;

  sum3_stream_accumulator #(.ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_acc(out_acc), .out_ovf(out_ovf), .out_last(out_last)
  );

  sum3_stream_accumulator #(.ACC_W(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid10), .out_ready(out_ready), .out_sum(out_sum10),
    .out_acc(out_acc10), .out_ovf(out_ovf10), .out_last(out_last10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic ci, input logic l);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_cin   = ci;
    in_last  = l;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_acc, out_ovf, out_last} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b sum=%0d acc=%0d ovf=%b last=%b, expected all 0",
               out_valid, out_sum, out_acc, out_ovf, out_last);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_beat;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: out_valid got %b expected 0 after one edge", out_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_acc, out_ovf, out_last} !== {1'b1, 10'd766, 16'd766, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_beat: got v=%b sum=%0d acc=%0d ovf=%b last=%b, expected v=1 sum=766 acc=766 ovf=0 last=1",
               out_valid, out_sum, out_acc, out_ovf, out_last);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [3] = '{8'd10, 8'd1, 8'd0};
    logic [7:0] vb [3] = '{8'd20, 8'd2, 8'd0};
    logic [7:0] vc [3] = '{8'd30, 8'd3, 8'd0};
    logic       vi [3] = '{1'b0, 1'b1, 1'b0};
    logic [9:0]  es [3] = '{10'd60, 10'd7, 10'd0};
    logic [15:0] ea [3] = '{16'd60, 16'd67, 16'd67};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) drive(1'b1, va[i], vb[i], vc[i], vi[i], i == 2);
      else       drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      #1;
      if (i < 3) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
        end
      end
      if (i >= 2) begin
        n_checks++;
        if ({out_valid, out_sum, out_acc, out_last} !== {1'b1, es[i-2], ea[i-2], i == 4}) begin
          n_fail++;
          $display("FAIL b2b_beat[%0d]: got v=%b sum=%0d acc=%0d last=%b, expected v=1 sum=%0d acc=%0d last=%b",
                   i - 2, out_valid, out_sum, out_acc, out_last, es[i-2], ea[i-2], i == 4);
        end
      end
    end
    // next frame must restart from zero
    @(negedge clk);
    drive(1'b1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_acc, out_last} !== {1'b1, 10'd3, 16'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_next_frame: got v=%b sum=%0d acc=%0d last=%b, expected v=1 sum=3 acc=3 last=1",
               out_valid, out_sum, out_acc, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'd10, 8'd20, 8'd30, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept0: in_ready got %b expected 1", in_ready);
    end
    @(negedge clk);
    drive(1'b1, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept1: in_ready got %b expected 1", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_sum, out_acc, out_last} !== {1'b0, 1'b1, 10'd60, 16'd60, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b sum=%0d acc=%0d last=%b, expected rdy=0 v=1 sum=60 acc=60 last=0",
                 i, in_ready, out_valid, out_sum, out_acc, out_last);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_acc, out_last} !== {1'b1, 1'b1, 10'd60, 16'd60, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_release0: got rdy=%b v=%b sum=%0d acc=%0d last=%b, expected rdy=1 v=1 sum=60 acc=60 last=0",
               in_ready, out_valid, out_sum, out_acc, out_last);
    end
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_acc, out_last} !== {1'b1, 10'd7, 16'd67, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_release1: got v=%b sum=%0d acc=%0d last=%b, expected v=1 sum=7 acc=67 last=0",
               out_valid, out_sum, out_acc, out_last);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_acc, out_last} !== {1'b1, 10'd0, 16'd67, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_release2: got v=%b sum=%0d acc=%0d last=%b, expected v=1 sum=0 acc=67 last=1",
               out_valid, out_sum, out_acc, out_last);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_acc_wrap;
    logic [9:0] ea [5] = '{10'd766, 10'd508, 10'd250, 10'd1016, 10'd766};
    logic       eo [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 5) drive(1'b1, 8'd255, 8'd255, 8'd255, 1'b1, el[i]);
      else       drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      #1;
      if (i >= 2) begin
        n_checks++;
        if ({out_valid10, out_sum10, out_acc10, out_ovf10, out_last10} !==
            {1'b1, 10'd766, ea[i-2], eo[i-2], el[i-2]}) begin
          n_fail++;
          $display("FAIL wrap10_beat[%0d]: got v=%b sum=%0d acc=%0d ovf=%b last=%b, expected v=1 sum=766 acc=%0d ovf=%b last=%b",
                   i - 2, out_valid10, out_sum10, out_acc10, out_ovf10, out_last10,
                   ea[i-2], eo[i-2], el[i-2]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'd255, 8'd245, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_acc} !== {1'b1, 16'd500}) begin
      n_fail++;
      $display("FAIL rstmid_setup: got v=%b acc=%0d, expected v=1 acc=500", out_valid, out_acc);
    end
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'd2, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({out_valid, out_acc, in_ready} !== {1'b1, 16'd501, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_inflight: got v=%b acc=%0d rdy=%b, expected v=1 acc=501 rdy=0",
               out_valid, out_acc, in_ready);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_acc, out_ovf, out_last, in_ready} !== {29'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_async: got v=%b sum=%0d acc=%0d ovf=%b last=%b rdy=%b, expected zeros and rdy=1",
               out_valid, out_sum, out_acc, out_ovf, out_last, in_ready);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 8'd5, 8'd0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sum, out_acc, out_ovf, out_last} !== {1'b1, 10'd5, 16'd5, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_restart: got v=%b sum=%0d acc=%0d ovf=%b last=%b, expected v=1 sum=5 acc=5 ovf=0 last=1",
               out_valid, out_sum, out_acc, out_ovf, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    beat_t       q[$];
    beat_t       exp_b;
    beat_t       got_b;
    logic [15:0] acc_m;
    logic        ovf_m;
    logic [16:0] acc_new;
    logic [9:0]  s_m;
    int unsigned n_in;
    int unsigned n_out;
    acc_m = '0;
    ovf_m = 1'b0;
    n_in  = 0;
    n_out = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        drive($urandom_range(99) < 70, 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), $urandom_range(7) == 0);
        out_ready = $urandom_range(99) < 70;
      end else begin
        drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        n_out++;
        got_b = '{sum: out_sum, acc: out_acc, ovf: out_ovf, last: out_last};
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_unexpected: output beat sum=%0d acc=%0d with none outstanding",
                   out_sum, out_acc);
        end else begin
          exp_b = q.pop_front();
          if (got_b !== exp_b) begin
            n_fail++;
            $display("FAIL rand_beat[%0d]: got sum=%0d acc=%0d ovf=%b last=%b, expected sum=%0d acc=%0d ovf=%b last=%b",
                     n_out - 1, got_b.sum, got_b.acc, got_b.ovf, got_b.last,
                     exp_b.sum, exp_b.acc, exp_b.ovf, exp_b.last);
          end
        end
      end
      if (in_valid && in_ready) begin
        n_in++;
        s_m = 10'(in_a) + 10'(in_b) + 10'(in_c) + 10'(in_cin);
        acc_new = {1'b0, acc_m} + 17'(s_m);
        q.push_back('{sum: s_m, acc: acc_new[15:0], ovf: ovf_m | acc_new[16], last: in_last});
        if (in_last) begin
          acc_m = '0;
          ovf_m = 1'b0;
        end else begin
          acc_m = acc_new[15:0];
          ovf_m = ovf_m | acc_new[16];
        end
      end
    end
    n_checks++;
    if (n_in !== n_out || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d beats out, expected %0d (outstanding %0d)",
               n_out, n_in, q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset;
    test_single_beat;
    test_back_to_back;
    test_backpressure;
    test_acc_wrap;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
